// File: rtl/plab5_mcore_mem_req_net_tdm_pkg.sv
// Shared definitions for the TDM memory-request network: message field
// layout {type, opaque, addr, len, data}, width helpers and mode encoding.
package plab5_mcore_mem_req_net_tdm_pkg;

  localparam int TYPE_NBITS = 3;
  localparam int LEN_NBITS  = 2;

  typedef enum logic {
    MODE_INSECURE = 1'b0,
    MODE_SECURE   = 1'b1
  } mode_e;

  function automatic int msg_nbits(input int o, input int a, input int d);
    return TYPE_NBITS + o + a + LEN_NBITS + d;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int len_lsb(input int d);
    return d;
  endfunction

  function automatic int addr_lsb(input int d);
    return d + LEN_NBITS;
  endfunction

  function automatic int opaque_lsb(input int a, input int d);
    return d + LEN_NBITS + a;
  endfunction

  function automatic int type_lsb(input int o, input int a, input int d);
    return d + LEN_NBITS + a + o;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_net_tdm_queue.sv
// Circular-buffer FIFO for one input port; ready comes purely from
// registered occupancy and is held low while the clear is asserted.
module plab5_mcore_mem_req_net_tdm_queue
  import plab5_mcore_mem_req_net_tdm_pkg::*;
#(
  parameter int p_depth = 2,
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  localparam int AW = min1_clog2(p_depth);
  localparam int CW = $clog2(p_depth + 1);

  logic [p_nbits-1:0] mem_q [p_depth];
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               enq_fire;
  logic               deq_fire;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] ptr);
    return (ptr == AW'(p_depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign enq_rdy  = clr_n && (cnt_q != CW'(p_depth));
  assign deq_val  = (cnt_q != '0);
  assign deq_msg  = mem_q[rd_q];
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (enq_fire) wr_d = bump(wr_q);
    if (deq_fire) rd_d = bump(rd_q);
    if (enq_fire && !deq_fire) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!enq_fire && deq_fire) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < p_depth; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (enq_fire) mem_q[wr_q] <= enq_msg;
    end
  end

endmodule

// File: rtl/plab5_mcore_mem_req_net_tdm.sv
// N-port memory-request network: per-port FIFOs, per-bank round-robin
// arbiters, and an optional TDM domain filter that isolates grant timing.
module plab5_mcore_mem_req_net_tdm
  import plab5_mcore_mem_req_net_tdm_pkg::*;
#(
  parameter int p_num_ports        = 4,
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_num_domains      = 2,
  parameter int p_slot_cycles      = 8,
  parameter int p_queue_depth      = 2,
  parameter int p_bank_lsb         = 4,
  parameter int p_single_bank      = 0,
  localparam int M  = msg_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
  localparam int P  = p_num_ports,
  localparam int DW = min1_clog2(p_num_domains),
  localparam int SW = min1_clog2(p_num_ports)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [P*M-1:0]  in_msg,
  input  logic [P*DW-1:0] in_domain,
  input  logic [P-1:0]    in_val,
  output logic [P-1:0]    in_rdy,
  output logic [P*M-1:0]  out_msg,
  output logic [P*DW-1:0] out_domain,
  output logic [P*SW-1:0] out_src,
  output logic [P-1:0]    out_val,
  input  logic [P-1:0]    out_rdy,
  output logic [DW-1:0]   cur_slot
);

  localparam int QW       = M + DW;
  localparam int CW       = min1_clog2(p_slot_cycles);
  localparam int DEST_LSB = addr_lsb(p_mem_data_nbits) + p_bank_lsb;

  logic [P-1:0]        q_deq_val;
  logic [P-1:0]        q_deq_rdy;
  logic [QW-1:0]       q_deq_msg [P];
  logic [M-1:0]        head_msg  [P];
  logic [DW-1:0]       head_dom  [P];
  logic [SW-1:0]       head_dest [P];

  logic [P-1:0][P-1:0] elig;
  logic [P-1:0]        gnt_val;
  logic [SW-1:0]       gnt_idx [P];

  mode_e               mode_q;
  logic [SW-1:0]       ptr_q [P];
  logic [SW-1:0]       ptr_d [P];
  logic [CW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]       cur_slot_q, cur_slot_d;

  function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % P;
    return SW'(s);
  endfunction

  for (genvar k = 0; k < P; k++) begin : g_port
    plab5_mcore_mem_req_net_tdm_queue #(
      .p_depth (p_queue_depth),
      .p_nbits (QW)
    ) u_queue (
      .clk     (clk),
      .clr_n   (reset),
      .enq_val (in_val[k]),
      .enq_rdy (in_rdy[k]),
      .enq_msg ({in_msg[k*M +: M], in_domain[k*DW +: DW]}),
      .deq_val (q_deq_val[k]),
      .deq_rdy (q_deq_rdy[k]),
      .deq_msg (q_deq_msg[k])
    );

    assign head_msg[k] = q_deq_msg[k][DW +: M];
    assign head_dom[k] = q_deq_msg[k][DW-1:0];

    if ((p_single_bank != 0) || (P == 1)) begin : g_dest_fixed
      assign head_dest[k] = '0;
    end else begin : g_dest_addr
      assign head_dest[k] = head_msg[k][DEST_LSB +: SW];
    end
  end

  // In secure mode only the domain owning the current slot may compete,
  // so foreign traffic can never shift another domain's grant cycle.
  always_comb begin
    elig = '0;
    for (int j = 0; j < P; j++) begin
      for (int k = 0; k < P; k++) begin
        elig[j][k] = q_deq_val[k] && (head_dest[k] == SW'(j)) &&
                     ((mode_q == MODE_INSECURE) || (head_dom[k] == cur_slot_q));
      end
    end
  end

  always_comb begin
    for (int j = 0; j < P; j++) begin
      gnt_val[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int i = 0; i < P; i++) begin
        if (!gnt_val[j] && elig[j][rr_idx(ptr_q[j], i)]) begin
          gnt_val[j] = 1'b1;
          gnt_idx[j] = rr_idx(ptr_q[j], i);
        end
      end
    end
  end

  // Grant is recomputed every cycle; a stalled winner is not held.
  always_comb begin
    out_val    = gnt_val;
    out_msg    = '0;
    out_domain = '0;
    out_src    = '0;
    q_deq_rdy  = '0;
    ptr_d      = ptr_q;
    for (int j = 0; j < P; j++) begin
      if (gnt_val[j]) begin
        out_msg[j*M +: M]     = head_msg[gnt_idx[j]];
        out_domain[j*DW +: DW] = head_dom[gnt_idx[j]];
        out_src[j*SW +: SW]   = gnt_idx[j];
        if (out_rdy[j]) begin
          q_deq_rdy[gnt_idx[j]] = 1'b1;
          ptr_d[j]              = rr_idx(gnt_idx[j], 1);
        end
      end
    end
  end

  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    cur_slot_d = cur_slot_q;
    if (slot_cnt_q == CW'(p_slot_cycles - 1)) begin
      slot_cnt_d = '0;
      cur_slot_d = (cur_slot_q == DW'(p_num_domains - 1)) ? '0 : cur_slot_q + 1'b1;
    end
  end

  assign cur_slot = cur_slot_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= MODE_INSECURE;
      slot_cnt_q <= '0;
      cur_slot_q <= '0;
      for (int j = 0; j < P; j++) ptr_q[j] <= '0;
    end else begin
      mode_q     <= mode_e'(mode);
      slot_cnt_q <= slot_cnt_d;
      cur_slot_q <= cur_slot_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_req_net_tdm.sv
// Scoreboard bench: a queue-based reference model predicts every transfer
// (bank, cycle, payload, source) and a monitor pops and compares them.
module tb_plab5_mcore_mem_req_net_tdm;

  localparam int P        = 4;
  localparam int O        = 8;
  localparam int A        = 32;
  localparam int D        = 32;
  localparam int ND       = 2;
  localparam int SLOT     = 8;
  localparam int DEPTH    = 2;
  localparam int BLSB     = 4;
  localparam int M        = 3 + O + A + 2 + D;
  localparam int DW       = 1;
  localparam int SW       = 2;
  localparam int ADDR_LSB = D + 2;
  localparam int DEST_LSB = ADDR_LSB + BLSB;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mode = 1'b0;
  logic [P*M-1:0]  in_msg = '0;
  logic [P*DW-1:0] in_domain = '0;
  logic [P-1:0]    in_val = '0;
  logic [P-1:0]    in_rdy;
  logic [P*M-1:0]  out_msg;
  logic [P*DW-1:0] out_domain;
  logic [P*SW-1:0] out_src;
  logic [P-1:0]    out_val;
  logic [P-1:0]    out_rdy = '0;
  logic [DW-1:0]   cur_slot;

  always #5 clk = ~clk;

  plab5_mcore_mem_req_net_tdm #(
    .p_num_ports        (P),
    .p_mem_opaque_nbits (O),
    .p_mem_addr_nbits   (A),
    .p_mem_data_nbits   (D),
    .p_num_domains      (ND),
    .p_slot_cycles      (SLOT),
    .p_queue_depth      (DEPTH),
    .p_bank_lsb         (BLSB),
    .p_single_bank      (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .in_msg     (in_msg),
    .in_domain  (in_domain),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .out_msg    (out_msg),
    .out_domain (out_domain),
    .out_src    (out_src),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .cur_slot   (cur_slot)
  );

  typedef struct {
    logic [M-1:0]  msg;
    logic [DW-1:0] dom;
  } ent_t;

  typedef struct {
    int            cyc;
    logic [M-1:0]  msg;
    logic [DW-1:0] dom;
    int            src;
  } exp_t;

  ent_t mq [P][$];
  exp_t eq [P][$];
  int   rr [P];
  int   cyc = 0;
  logic mode_qm = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   tdm_gcyc = -1;
  bit   tdm_arm = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int dest_of(input logic [M-1:0] m);
    return int'(m[DEST_LSB +: SW]);
  endfunction

  function automatic logic [M-1:0] rand_msg(input int bank);
    logic [M-1:0] m;
    m = M'({$urandom(), $urandom(), $urandom()});
    m[DEST_LSB +: SW] = SW'(bank);
    return m;
  endfunction

  // Monitor: every DUT transfer must match the oldest prediction for its bank.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        for (int j = 0; j < P; j++) begin
          if (out_val[j] && out_rdy[j]) begin
            int   src;
            exp_t e;
            src = int'(out_src[j*SW +: SW]);
            if (tdm_arm && j == 0 && src == 0 && tdm_gcyc < 0) tdm_gcyc = cyc;
            if (eq[j].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_xfer bank %0d: got transfer from src %0d, required none (cycle %0d)", j, src, cyc);
            end else begin
              e = eq[j].pop_front();
              chk("xfer_cycle", 128'(cyc), 128'(e.cyc));
              chk("xfer_msg", 128'(out_msg[j*M +: M]), 128'(e.msg));
              chk("xfer_dom", 128'(out_domain[j*DW +: DW]), 128'(e.dom));
              chk("xfer_src", 128'(src), 128'(e.src));
            end
          end
        end
      end
    end
  end

  // One clock cycle: drive inputs, run the reference model, advance time.
  task automatic step(input logic [P-1:0] v, input logic [P*M-1:0] msgs,
                      input logic [P*DW-1:0] doms, input logic [P-1:0] rdy, input logic md);
    logic [P-1:0] er;
    logic [P-1:0] ev;
    logic [P-1:0] popm;
    int           slot;
    int           k;
    ent_t         h;
    in_val    = v;
    in_msg    = msgs;
    in_domain = doms;
    out_rdy   = rdy;
    mode      = md;
    #1;
    slot = (cyc / SLOT) % ND;
    popm = '0;
    ev   = '0;
    for (int p = 0; p < P; p++) er[p] = (mq[p].size() < DEPTH);
    chk("in_rdy", 128'(in_rdy), 128'(er));
    chk("cur_slot", 128'(cur_slot), 128'(slot));
    for (int j = 0; j < P; j++) begin
      for (int i = 0; i < P; i++) begin
        k = (rr[j] + i) % P;
        if (!ev[j] && mq[k].size() > 0) begin
          h = mq[k][0];
          if (dest_of(h.msg) == j && (!mode_qm || int'(h.dom) == slot)) begin
            ev[j] = 1'b1;
            if (rdy[j]) begin
              eq[j].push_back('{cyc, h.msg, h.dom, k});
              popm[k] = 1'b1;
              rr[j]   = (k + 1) % P;
            end
          end
        end
      end
    end
    chk("out_val", 128'(out_val), 128'(ev));
    for (int p = 0; p < P; p++) begin
      if (popm[p]) void'(mq[p].pop_front());
      if (v[p] && er[p]) mq[p].push_back('{msgs[p*M +: M], doms[p*DW +: DW]});
    end
    @(posedge clk);
    cyc++;
    mode_qm = md;
    @(negedge clk);
  endtask

  task automatic rand_step(input int pval, input int prdy, input logic md);
    logic [P-1:0]    v;
    logic [P-1:0]    r;
    logic [P*M-1:0]  ms;
    logic [P*DW-1:0] ds;
    for (int p = 0; p < P; p++) begin
      v[p] = (int'($urandom_range(99)) < pval);
      r[p] = (int'($urandom_range(99)) < prdy);
      ms[p*M +: M]   = rand_msg(int'($urandom_range(P - 1)));
      ds[p*DW +: DW] = DW'($urandom_range(ND - 1));
    end
    step(v, ms, ds, r, md);
  endtask

  task automatic do_reset(input int hold);
    reset   = 1'b0;
    in_val  = '0;
    out_rdy = '1;
    mode    = 1'b0;
    #1;
    chk("rst_out_val", 128'(out_val), 128'(0));
    chk("rst_in_rdy", 128'(in_rdy), 128'(0));
    chk("rst_cur_slot", 128'(cur_slot), 128'(0));
    chk("rst_out_msg_zero", 128'(|{out_msg, out_domain, out_src}), 128'(0));
    repeat (hold) @(negedge clk);
    chk("rst_hold_out_val", 128'(out_val), 128'(0));
    chk("rst_hold_in_rdy", 128'(in_rdy), 128'(0));
    for (int p = 0; p < P; p++) begin
      mq[p].delete();
      eq[p].delete();
      rr[p] = 0;
    end
    cyc     = 0;
    mode_qm = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic tdm_run(input bit flood, output int g);
    logic [P-1:0]    v;
    logic [P*M-1:0]  ms;
    logic [P*DW-1:0] ds;
    do_reset(2);
    tdm_gcyc = -1;
    tdm_arm  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      v  = '0;
      ms = '0;
      ds = '0;
      if (c == 1) begin
        v[0]      = 1'b1;
        ms[0 +: M] = rand_msg(0);
        ds[0 +: DW] = 1'b1;
      end
      if (flood) begin
        for (int p = 1; p < P; p++) begin
          v[p]           = 1'b1;
          ms[p*M +: M]   = rand_msg(0);
          ds[p*DW +: DW] = '0;
        end
      end
      step(v, ms, ds, '1, 1'b1);
    end
    tdm_arm = 1'b0;
    g = tdm_gcyc;
  endtask

  initial begin
    logic [P*M-1:0]  ms;
    logic [P*DW-1:0] ds;
    logic [M-1:0]    m0;
    logic [M-1:0]    bp [3];
    logic            md;
    int              sent;
    int              g_quiet;
    int              g_flood;
    bit              empty;

    @(negedge clk);
    do_reset(3);

    // Latency and routing: port 2, addr 0x30 -> bank 3 one cycle later.
    m0 = rand_msg(0);
    m0[ADDR_LSB +: A] = 32'h0000_0030;
    ms = '0;
    ms[2*M +: M] = m0;
    step(4'b0100, ms, '0, '1, 1'b0);
    chk("lat_val_bank3", 128'(out_val), 128'(4'b1000));
    chk("lat_src_bank3", 128'(out_src[3*SW +: SW]), 128'(2));
    chk("lat_msg_bank3", 128'(out_msg[3*M +: M]), 128'(m0));
    step('0, '0, '0, '1, 1'b0);

    // Round-robin: all ports stream to bank 1.
    for (int c = 0; c < 14; c++) begin
      for (int p = 0; p < P; p++) ms[p*M +: M] = rand_msg(1);
      step('1, ms, '0, '1, 1'b0);
    end
    for (int c = 0; c < 6; c++) step('0, '0, '0, '1, 1'b0);

    // Backpressure: bank 1 stalled for 5 cycles while port 0 offers 3 requests.
    for (int i = 0; i < 3; i++) bp[i] = rand_msg(1);
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) chk("bp_in_rdy0_full", 128'(in_rdy[0]), 128'(0));
      ms = '0;
      ms[0 +: M] = bp[(sent < 3) ? sent : 2];
      if (sent < 3 && in_rdy[0]) begin
        step({3'b000, 1'b1}, ms, '0, (c >= 5) ? 4'b1111 : 4'b1101, 1'b0);
        sent++;
      end else begin
        step({3'b000, sent < 3}, ms, '0, (c >= 5) ? 4'b1111 : 4'b1101, 1'b0);
      end
    end

    // Randomised traffic: insecure, secure, then with mode toggling.
    for (int c = 0; c < 300; c++) rand_step(60, 70, 1'b0);
    for (int c = 0; c < 300; c++) rand_step(60, 70, 1'b1);
    md = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(9) == 0) md = ~md;
      rand_step(50, 75, md);
    end

    // Reset while FIFOs hold traffic; nothing stale may surface afterwards.
    for (int c = 0; c < 10; c++) rand_step(90, 0, 1'b0);
    do_reset(2);
    for (int c = 0; c < 4; c++) step('0, '0, '0, '1, 1'b0);

    // Domain-1 grant timing must not depend on domain-0 load.
    tdm_run(1'b0, g_quiet);
    tdm_run(1'b1, g_flood);
    chk("tdm_grant_quiet", 128'(g_quiet), 128'(8));
    chk("tdm_grant_flood", 128'(g_flood), 128'(8));
    chk("tdm_grant_same", 128'(g_flood), 128'(g_quiet));

    // Drain everything in insecure mode.
    for (int c = 0; c < 60; c++) begin
      empty = 1'b1;
      for (int p = 0; p < P; p++) if (mq[p].size() != 0) empty = 1'b0;
      if (empty) break;
      step('0, '0, '0, '1, 1'b0);
    end
    step('0, '0, '0, '1, 1'b0);
    chk("drain_out_val", 128'(out_val), 128'(0));
    chk("drain_in_rdy", 128'(in_rdy), 128'(4'b1111));
    for (int p = 0; p < P; p++) chk("drain_model_empty", 128'(mq[p].size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_req_net_tdm.md
Name: plab5_mcore_mem_req_net_tdm

Overview:
Parametrised N-port memory-request network connecting processor/cache request ports to memory banks, with a per-message security-domain tag.
- Each input port has a small FIFO.
- Each output bank has a round-robin arbiter.
- Secure mode adds time-division-multiplexed (TDM) domain slots, so one domain's traffic cannot change the grant timing seen by another domain.
- Sits between the cache request adapters and the bank request ports; `out_src` carries the source id so the response path can route back.

Parameters:
- p_num_ports, 4, number of input ports and of output banks.
- p_mem_opaque_nbits, 8, opaque field width (o).
- p_mem_addr_nbits, 32, address field width (a).
- p_mem_data_nbits, 32, data field width (d).
- p_num_domains, 2, number of security domains (domain width dw = max(1, clog2(p_num_domains))).
- p_slot_cycles, 8, cycles per TDM slot (at least 1).
- p_queue_depth, 2, entries per input FIFO (at least 1).
- p_bank_lsb, 4, lowest address bit of the bank index.
- p_single_bank, 0, when 1 every request targets bank 0.

Ports:
Message width m = 3+o+a+2+d, laid out as {type, opaque, addr, len, data}; P = p_num_ports; sw = clog2(P).
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset (asserted when 0).
- mode, in, 1, 0 = insecure work-conserving, 1 = secure TDM.
- in_msg, in, P*m, request message per port (port k at bits [k*m +: m]).
- in_domain, in, P*dw, domain tag per port.
- in_val, in, P, per-port valid.
- in_rdy, out, P, per-port ready.
- out_msg, out, P*m, request message to each bank.
- out_domain, out, P*dw, domain of the granted request.
- out_src, out, P*sw, input port id of the granted request.
- out_val, out, P, per-bank valid.
- out_rdy, in, P, per-bank ready.
- cur_slot, out, dw, domain owning the current TDM slot.

Behaviour:
- Reset (reset==0, asynchronous):
  - All FIFOs empty; round-robin pointers = 0; slot counter = 0; cur_slot = 0; mode_q = 0.
  - in_rdy = 0 while reset is asserted.
  - out_val = 0; out_msg/out_domain/out_src = 0.
- Clocking: every register is posedge clk with asynchronous clear. mode is registered into mode_q, and all arbitration uses mode_q, so a mode change takes effect one cycle later.
- Input FIFO k:
  - in_rdy[k] = not full, from registered occupancy; there is no same-cycle dequeue credit.
  - Enqueue on in_val&in_rdy, storing {msg, domain}.
  - There is no bypass path, so minimum latency from enqueue to out_val is 1 cycle.
  - Simultaneous enqueue and dequeue on a full FIFO is impossible, because in_rdy=0 when full.
  - On a non-full FIFO, simultaneous enqueue and dequeue keeps occupancy unchanged.
- Destination of FIFO head k:
  - dest = addr[p_bank_lsb +: sw], where addr = msg[d+2 +: a].
  - dest = 0 when p_single_bank==1 or P==1.
- Eligibility: head k is eligible for bank j iff the FIFO is non-empty, dest==j, and (mode_q==0 or head domain==cur_slot).
- Arbitration per bank j:
  - Round-robin among eligible heads, starting from ptr[j].
  - out_val[j] = 1 if any head is eligible; out_msg/out_domain/out_src come from the grantee and are 0 when out_val=0.
  - On out_val&out_rdy: dequeue the grantee and set ptr[j] = grantee+1 mod P.
  - ptr is unchanged when out_rdy=0. A granted-but-stalled head may be overtaken by a higher-priority arrival; the grant is not sticky.
- A head targets exactly one bank, so no input is ever dequeued twice in a cycle. Different banks transfer in parallel.
- TDM slot counter:
  - Free-runs 0..p_slot_cycles-1 in both modes.
  - On wrap, cur_slot = cur_slot+1 mod p_num_domains.
  - Slot boundary: grants follow the cur_slot value of that cycle. In secure mode, a head of the other domain waits even if the bank is idle (non-work-conserving by design).
- No fail/drop path exists: every accepted request is eventually delivered, provided out_rdy is eventually asserted.

Decomposition:
- Shared package/include (plab5-mcore-define): field offsets (type, opaque, addr, len, data), message-width macro, dw/sw clog2 expressions, mode encodings SECURE=1 and INSECURE=0.
- Sub-module plab5_mcore_mem_req_net_tdm_queue: parametrised FIFO (depth, width), with enq_val/enq_rdy, deq_val/deq_rdy and an async active-low clear. It is instantiated P times.
- The arbiter and slot logic stay in the top module.

Test Plan:
1. Reset and idle:
   - Stimulus: assert reset=0 mid-transfer with FIFOs non-empty, then release.
   - Required: all out_val=0, cur_slot=0, in_rdy=0 during reset and in_rdy=1111 the cycle after release; no stale message emerges.
2. Insecure latency and routing (P=4, p_bank_lsb=4):
   - Stimulus: port 2 sends addr 0x00000030 at cycle 0.
   - Required: out_val[3]=1 at cycle 1 with out_src[3]=2 and the message unchanged; with p_single_bank=1 it appears on bank 0 instead.
3. Round-robin fairness:
   - Stimulus: ports 0-3 each continuously send to bank 1 with out_rdy=1.
   - Required: grants in order 0,1,2,3,0,...; one transfer per cycle; ptr advances only on transfer.
4. Backpressure:
   - Stimulus: out_rdy[1]=0 for 5 cycles while port 0 sends 3 requests (depth 2).
   - Required: in_rdy[0]=0 after 2 accepts; nothing is lost; messages drain in FIFO order once out_rdy=1.
5. Secure TDM (mode=1, p_slot_cycles=8):
   - Stimulus: port 0 (domain 1) sends at cycle 1.
   - Required: no grant until cycles 8-15 (cur_slot=1); a domain-0 flood on other ports does not alter the domain-1 grant cycle, whose timing must be identical with and without the flood.
6. Mode switch:
   - Stimulus: mode 0→1 at cycle N while a domain-1 request is pending in a domain-0 slot.
   - Required: granted at cycle N if still in insecure mode_q, otherwise held until cur_slot=1.
